// File: rtl/ysyx_22050535_wb_arbiter_pkg.sv
// Shared widths and requester encoding for the write-back arbiter slice.
// Values mirror the core-wide register-file parameters.
package ysyx_22050535_wb_arbiter_pkg;

  localparam int ysyx_22050535_DATA_WIDTH = 32;
  localparam int ysyx_22050535_ADDR_WIDTH = 5;
  localparam int ysyx_22050535_REG_NUM    = 32;

  // Requester IDs, also the encoding of the round-robin pointer.
  typedef enum logic {
    ysyx_22050535_WB_EXU = 1'b0,
    ysyx_22050535_WB_LSU = 1'b1
  } wb_req_e;

endpackage

// File: rtl/ysyx_22050535_wb_arbiter_scoreboard.sv
// Busy-bit scoreboard: tracks destination registers with uncommitted writes
// and raises a stall for any candidate touching one of them.
module ysyx_22050535_scoreboard
  import ysyx_22050535_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ysyx_22050535_ADDR_WIDTH,
  parameter int REG_NUM = ysyx_22050535_REG_NUM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_rd,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_rd,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  output logic              stall,
  output logic              empty
);

  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_nxt;
  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] clr_mask;
  logic [REG_NUM-1:0] x0_mask;

  // Clear is applied before set so a same-edge set wins; bit 0 is forced low.
  always_comb begin
    set_mask = {{(REG_NUM-1){1'b0}}, set_en} << set_rd;
    clr_mask = {{(REG_NUM-1){1'b0}}, clr_en} << clr_rd;
    x0_mask  = {{(REG_NUM-1){1'b0}}, 1'b1};
    busy_nxt = ((busy & ~clr_mask) | set_mask) & ~x0_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= {REG_NUM{1'b0}};
    end else if (flush) begin
      busy <= {REG_NUM{1'b0}};
    end else begin
      busy <= busy_nxt;
    end
  end

  assign stall = busy[rs1] | busy[rs2] | busy[rd];
  assign empty = ~|busy;

endmodule

// File: rtl/ysyx_22050535_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between EXU and
// LSU, with a one-cycle registered write stage and a hazard scoreboard.
module ysyx_22050535_wb_arbiter
  import ysyx_22050535_wb_arbiter_pkg::*;
#(
  parameter int DATA_W  = ysyx_22050535_DATA_WIDTH,
  parameter int ADDR_W  = ysyx_22050535_ADDR_WIDTH,
  parameter int REG_NUM = ysyx_22050535_REG_NUM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] iss_rs1,
  input  logic [ADDR_W-1:0] iss_rs2,
  output logic              iss_stall,
  input  logic              flush,
  output logic              sb_empty
);

  wb_req_e           last_grant;
  logic              grant_exu;
  logic              grant_lsu;
  logic              grant_any;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  // On a conflict the requester that did not win last time is granted.
  always_comb begin
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (exu_valid && lsu_valid) begin
      if (last_grant == ysyx_22050535_WB_LSU) begin
        grant_exu = 1'b1;
      end else begin
        grant_lsu = 1'b1;
      end
    end else if (exu_valid) begin
      grant_exu = 1'b1;
    end else if (lsu_valid) begin
      grant_lsu = 1'b1;
    end else begin
      grant_exu = 1'b0;
      grant_lsu = 1'b0;
    end
  end

  assign grant_any = grant_exu | grant_lsu;
  assign sel_rd    = grant_lsu ? lsu_rd   : exu_rd;
  assign sel_data  = grant_lsu ? lsu_data : exu_data;
  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;

  // Reset to LSU so that EXU wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ysyx_22050535_WB_LSU;
    end else if (grant_exu) begin
      last_grant <= ysyx_22050535_WB_EXU;
    end else if (grant_lsu) begin
      last_grant <= ysyx_22050535_WB_LSU;
    end
  end

  // x0 writes complete the handshake but never raise the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= {ADDR_W{1'b0}};
      rf_wdata <= {DATA_W{1'b0}};
    end else if (grant_any) begin
      rf_wen   <= (sel_rd != {ADDR_W{1'b0}});
      rf_waddr <= sel_rd;
      rf_wdata <= sel_data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  ysyx_22050535_scoreboard #(
    .ADDR_W (ADDR_W),
    .REG_NUM(REG_NUM)
  ) u_scoreboard (
    .clk   (clk),
    .rst_n (rst_n),
    .set_en(iss_valid),
    .set_rd(iss_rd),
    .clr_en(rf_wen),
    .clr_rd(rf_waddr),
    .flush (flush),
    .rs1   (iss_rs1),
    .rs2   (iss_rs2),
    .rd    (iss_rd),
    .stall (iss_stall),
    .empty (sb_empty)
  );

endmodule
